d_stage_front: RTL
==================

# d_stage_front

Decode-stage front end of the five-stage MIPS pipeline, directly downstream of the fetch unit.
- Holds the F/D pipeline register, with stall and reset.
- Forwards `rs`/`rt` operands from the E and M stages.
- Performs the branch compare.
- Classifies control-flow instructions.
- Returns `branchEn`, `offset`, `instr_index`, `rsIn`, `D_pcPlus4` and `jumpOp` to the fetch unit, closing the next-PC loop within one cycle.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: value loaded into `D_pc` on reset.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `stall`, input, 1: from the hazard unit; holds the F/D register.
- `F_instr`, input, 32: instruction fetched at `F_pc`.
- `F_pc`, input, 32: fetch-stage PC.
- `rf_rs`, input, 32: register-file read data for `D_instr[25:21]`.
- `rf_rt`, input, 32: register-file read data for `D_instr[20:16]`.
- `E_fwdAddr`, input, 5: E-stage destination register.
- `E_fwdData`, input, 32: E-stage forwarding value.
- `E_fwdValid`, input, 1: E-stage value is ready.
- `M_fwdAddr`, input, 5: M-stage destination register.
- `M_fwdData`, input, 32: M-stage forwarding value.
- `M_fwdValid`, input, 1: M-stage value is ready.
- `D_instr`, output, 32: registered instruction.
- `D_pc`, output, 32: registered PC.
- `D_pcPlus4`, output, 32: `D_pc + 4`.
- `rsAddr`, `rtAddr`, output, 5 each: `D_instr[25:21]` and `D_instr[20:16]`.
- `rsVal`, `rtVal`, output, 32 each: forwarded operands.
- `rsIn`, output, 32: equals `rsVal`; jr/jalr target.
- `offset`, output, 16: `D_instr[15:0]`.
- `instr_index`, output, 26: `D_instr[25:0]`.
- `jumpOp`, output, 3: 0 none, 1 branch, 2 j/jal, 3 jr/jalr.
- `branchEn`, output, 1: branch condition true.

## Operation
F/D register:
- Reset loads `D_instr=0` (nop) and `D_pc=RESET_PC`. Reset wins over `stall`.
- With `stall=1`, `D_instr` and `D_pc` hold their values.
- Otherwise `D_instr` and `D_pc` capture `F_instr` and `F_pc` on every rising edge.
- No flush exists. The architecture uses delayed branches, so the delay-slot instruction is always captured.

Forwarding, per operand (`rs` and `rt` independently):
- If addr==0, the value is 0.
- Else if addr==`E_fwdAddr` and `E_fwdValid`, use `E_fwdData`.
- Else if addr==`M_fwdAddr` and `M_fwdValid`, use `M_fwdData`.
- Else use the RF data. W→D bypass is handled inside the RF.
- E has priority over M.

Control classification (opcode=`[31:26]`, funct=`[5:0]`):
- beq 000100, bne 000101, blez 000110, bgtz 000111 → `jumpOp=1`.
- REGIMM 000001 with `rt=00001` (bgez) or `rt=00000` (bltz) → `jumpOp=1`. Other REGIMM `rt` values → `jumpOp=0`.
- j 000010, jal 000011 → `jumpOp=2`.
- SPECIAL 000000 with funct 001000 (jr) or 001001 (jalr) → `jumpOp=3`.
- All else → `jumpOp=0`.

Branch compare (signed, on forwarded values):
- beq: `rsVal==rtVal`. bne: `!=`.
- blez: `rsVal<=0`. bgtz: `rsVal>0`.
- bgez: `rsVal>=0`. bltz: `rsVal<0`.
- `branchEn=0` whenever `jumpOp!=1`.

## Timing
- All outputs are combinational from the F/D register plus forwarding inputs; there is no extra latency.
- `branchEn`/`jumpOp` in cycle n steer the fetch unit's PC update at the edge ending cycle n.
- During stall, `branchEn` may reflect stale operands. This is harmless because the fetch unit is disabled by the same stall. Correct values are required in the first non-stall cycle.
- Reset mid-stream: the next cycle presents a nop with `jumpOp=0` and `branchEn=0`.
- `D_pcPlus4` wraps modulo 2^32.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: `OP_SPECIAL`, `OP_REGIMM`, `OP_BEQ`, `OP_BNE`, `OP_BLEZ`, `OP_BGTZ`, `OP_J`, `OP_JAL`;
  - funct constants: `FN_JR`, `FN_JALR`;
  - the `jumpOp` encoding constants `JOP_NONE`, `JOP_BR`, `JOP_J`, `JOP_JR`;
  - the reset-PC constant.
- One sub-module: `cmp`, the branch comparator. Inputs: `rsVal`, `rtVal`, opcode, `rt` field. Output: `branchEn`.
- Forwarding muxes and classification stay inline.

## Test plan
- Reset, then `stall=0` with `F_instr=32'h0000_0000`, `F_pc=32'h3000`:
  - after the reset cycle, `D_pc=32'h3000` and `jumpOp=0`;
  - next cycle, `D_pcPlus4=32'h3004`.
- beq $1,$2, with `rf_rs=rf_rt=5` → `jumpOp=1`, `branchEn=1`. With `rf_rt=6` → `branchEn=0`.
- bltz $3, `rf_rs=32'hFFFF_FFFF` → `branchEn=1`. bgtz with `rs=0` → `branchEn=0`.
- jr $31, `rf_rs=1`, `E_fwdAddr=31`, `E_fwdValid=1`, `E_fwdData=32'h3040`, M also matching with `32'h3080`:
  - `rsIn=32'h3040`, `jumpOp=3`;
  - with `E_fwdValid=0`, `rsIn=32'h3080`.
- Forward to $0: `rsAddr=0`, `E_fwdAddr=0`, `E_fwdData=7` → `rsVal=0`.
- Stall held for 3 cycles while `F_instr` changes → `D_instr` and `D_pc` unchanged. Reset asserted during stall → `D_instr=0`, `D_pc=32'h3000` next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcode/funct fields, next-PC control encoding and reset PC.
// Field extraction helpers keep bit slicing consistent across decode logic.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // REGIMM branch selectors live in the rt field
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [2:0] JOP_NONE   = 3'd0;
    localparam logic [2:0] JOP_BR     = 3'd1;
    localparam logic [2:0] JOP_J      = 3'd2;
    localparam logic [2:0] JOP_JR     = 3'd3;

    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_3000;

    function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/d_stage_front_cmp.sv
// Branch comparator: evaluates the branch condition for conditional branches on
// forwarded operands; deasserts for anything that is not a recognised branch.
module cmp
    import mips_pkg::*;
(
    input  logic [31:0] rsVal,
    input  logic [31:0] rtVal,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    output logic        branchEn
);

    logic rs_eq_rt;
    logic rs_neg;
    logic rs_zero;

    assign rs_eq_rt = (rsVal == rtVal);
    assign rs_neg   = rsVal[31];
    assign rs_zero  = (rsVal == 32'd0);

    always_comb begin
        branchEn = 1'b0;
        unique case (opcode)
            OP_BEQ:  branchEn = rs_eq_rt;
            OP_BNE:  branchEn = !rs_eq_rt;
            OP_BLEZ: branchEn = rs_neg || rs_zero;
            OP_BGTZ: branchEn = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (rt == RT_BGEZ)
                    branchEn = !rs_neg;
                else if (rt == RT_BLTZ)
                    branchEn = rs_neg;
            end
            default: branchEn = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_stage_front.sv
// Decode-stage front end: F/D register, E/M operand forwarding, control-flow
// classification and branch compare feeding the fetch unit's next-PC logic.
module d_stage_front
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic [31:0] F_pc,
    input  logic [31:0] rf_rs,
    input  logic [31:0] rf_rt,
    input  logic [4:0]  E_fwdAddr,
    input  logic [31:0] E_fwdData,
    input  logic        E_fwdValid,
    input  logic [4:0]  M_fwdAddr,
    input  logic [31:0] M_fwdData,
    input  logic        M_fwdValid,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pcPlus4,
    output logic [4:0]  rsAddr,
    output logic [4:0]  rtAddr,
    output logic [31:0] rsVal,
    output logic [31:0] rtVal,
    output logic [31:0] rsIn,
    output logic [15:0] offset,
    output logic [25:0] instr_index,
    output logic [2:0]  jumpOp,
    output logic        branchEn
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    // No flush path: the delay-slot instruction is always captured.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (reset) begin
            instr_d = 32'd0;
            pc_d    = RESET_PC;
        end else if (!stall) begin
            instr_d = F_instr;
            pc_d    = F_pc;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    logic [5:0] opcode;
    logic [5:0] funct;

    assign D_instr     = instr_q;
    assign D_pc        = pc_q;
    assign D_pcPlus4   = pc_q + 32'd4;
    assign opcode      = instr_opcode(instr_q);
    assign funct       = instr_funct(instr_q);
    assign rsAddr      = instr_rs(instr_q);
    assign rtAddr      = instr_rt(instr_q);
    assign offset      = instr_q[15:0];
    assign instr_index = instr_q[25:0];

    // $0 is hardwired; E is newer than M so it wins when both match.
    always_comb begin
        if (rsAddr == 5'd0)
            rsVal = 32'd0;
        else if (E_fwdValid && (rsAddr == E_fwdAddr))
            rsVal = E_fwdData;
        else if (M_fwdValid && (rsAddr == M_fwdAddr))
            rsVal = M_fwdData;
        else
            rsVal = rf_rs;
    end

    always_comb begin
        if (rtAddr == 5'd0)
            rtVal = 32'd0;
        else if (E_fwdValid && (rtAddr == E_fwdAddr))
            rtVal = E_fwdData;
        else if (M_fwdValid && (rtAddr == M_fwdAddr))
            rtVal = M_fwdData;
        else
            rtVal = rf_rt;
    end

    assign rsIn = rsVal;

    always_comb begin
        jumpOp = JOP_NONE;
        unique case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: jumpOp = JOP_BR;
            OP_REGIMM: begin
                if (rtAddr == RT_BGEZ || rtAddr == RT_BLTZ)
                    jumpOp = JOP_BR;
            end
            OP_J, OP_JAL: jumpOp = JOP_J;
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR)
                    jumpOp = JOP_JR;
            end
            default: jumpOp = JOP_NONE;
        endcase
    end

    cmp u_cmp (
        .rsVal    (rsVal),
        .rtVal    (rtVal),
        .opcode   (opcode),
        .rt       (rtAddr),
        .branchEn (branchEn)
    );

endmodule
